// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store path: access-size codes,
// LSU state encoding and the lane-mask/legality helpers used at accept time.
package ls_pkg;

  typedef enum logic [2:0] {
    LS_WORD  = 3'b000,
    LS_HALF  = 3'b001,
    LS_BYTE  = 3'b011,
    LS_BYTEU = 3'b100,
    LS_HALFU = 3'b101
  } ls_src_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } lsu_state_t;

  function automatic logic ls_legal(input logic [2:0] src);
    case (src)
      LS_WORD, LS_HALF, LS_BYTE, LS_BYTEU, LS_HALFU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ls_mask(input logic [2:0] src);
    case (src)
      LS_WORD:           return 4'hF;
      LS_HALF, LS_HALFU: return 4'h3;
      default:           return 4'h1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Valid/ready data-memory bus between the load/store unit and the memory.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_ls_extender.sv
// Byte/half sign or zero extension of right-justified load data.
module ls_extender
  import ls_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [2:0]  ls_src,
  output logic [31:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (ls_src)
      LS_HALF:  data_out = {{16{data_in[15]}}, data_in[15:0]};
      LS_HALFU: data_out = {16'h0000, data_in[15:0]};
      LS_BYTE:  data_out = {{24{data_in[7]}}, data_in[7:0]};
      LS_BYTEU: data_out = {24'h000000, data_in[7:0]};
      default:  data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store controls into one or two word beats
// on the data-memory bus and returns extended load data with a completion pulse.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             data_write_en,
  input  logic [2:0]       ls_src,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             resp_valid,
  output logic [WIDTH-1:0] rdata,
  output logic             ls_fault,
  load_store_unit_if.master bus
);

  lsu_state_t       state;
  logic [1:0]       off_q;
  logic [2:0]       src_q;
  logic             we_q;
  logic [3:0]       be_hi_q;
  logic [WIDTH-1:0] wd_hi_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] lo_q;

  logic [7:0]         be8_n;
  logic [2*WIDTH-1:0] wd64_n;
  logic [2*WIDTH-1:0] pair;
  logic [WIDTH-1:0]   aligned;
  logic [WIDTH-1:0]   ext_out;
  logic               split;
  logic               last_beat;

  always_comb begin
    be8_n  = {4'b0000, ls_mask(ls_src)} << addr[1:0];
    wd64_n = {{WIDTH{1'b0}}, wdata} << {addr[1:0], 3'b000};
    split  = |be_hi_q;
    // The beat currently completing supplies the newest word straight from the bus.
    pair    = (state == BEAT1) ? {bus.mem_rdata, lo_q} : {{WIDTH{1'b0}}, bus.mem_rdata};
    aligned = WIDTH'(pair >> {off_q, 3'b000});
    last_beat = bus.mem_ready && ((state == BEAT1) || (state == BEAT0 && !split));
    stall = (state == IDLE) ? req_valid : (state == BEAT0 || state == BEAT1);
  end

  ls_extender u_ext (
    .data_in  (aligned),
    .ls_src   (src_q),
    .data_out (ext_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      ls_fault      <= 1'b0;
      rdata         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      off_q         <= '0;
      src_q         <= '0;
      we_q          <= 1'b0;
      be_hi_q       <= '0;
      wd_hi_q       <= '0;
      word_q        <= '0;
      lo_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (ls_legal(ls_src)) begin
              off_q         <= addr[1:0];
              src_q         <= ls_src;
              we_q          <= data_write_en;
              be_hi_q       <= be8_n[7:4];
              wd_hi_q       <= wd64_n[2*WIDTH-1:WIDTH];
              word_q        <= {addr[WIDTH-1:2], 2'b00};
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= data_write_en;
              bus.mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              bus.mem_be    <= be8_n[3:0];
              bus.mem_wdata <= wd64_n[WIDTH-1:0];
              state         <= BEAT0;
            end else begin
              ls_fault   <= 1'b1;
              resp_valid <= 1'b1;
              rdata      <= '0;
              state      <= DONE;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
            lo_q <= bus.mem_rdata;
            if (split) begin
              bus.mem_addr  <= word_q + WIDTH'(4);
              bus.mem_be    <= be_hi_q;
              bus.mem_wdata <= wd_hi_q;
              state         <= BEAT1;
            end
          end
        end
        BEAT1: begin
        end
        DONE: begin
          resp_valid <= 1'b0;
          ls_fault   <= 1'b0;
          rdata      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (last_beat) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        bus.mem_be  <= '0;
        resp_valid  <= 1'b1;
        rdata       <= we_q ? '0 : ext_out;
        state       <= DONE;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart of the instruction controller. It consumes the controller's load/store controls (ls_src, data_write_en), the ALU-computed address and the rs2 store data.
- It drives a valid/ready data-memory bus with a word address, byte enables and lane-aligned write data.
- It returns load data sign- or zero-extended, and stalls the core until each access completes.
- Misaligned half/word accesses that cross a word boundary are split into two bus beats.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  load/store present this cycle; sampled only in IDLE
- data_write_en  in  1  1 = store, 0 = load
- ls_src  in  3  access size/extension code (ls_pkg)
- addr  in  WIDTH  byte address
- wdata  in  WIDTH  store data, right-justified
- stall  out  1  core must hold its pipeline
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  WIDTH  extended load data; valid with resp_valid
- ls_fault  out  1  illegal ls_src; valid with resp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  WIDTH  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-aligned write data
- mem_ready  in  1  bus accepts/completes the current beat
- mem_rdata  in  WIDTH  read data; valid when mem_ready is high on a read

Behaviour:
- Reset (rst == 0 at a clock edge):
  - State goes to IDLE.
  - stall, resp_valid, ls_fault, mem_req, mem_we and mem_be go to 0; rdata, mem_addr and mem_wdata go to 0.
  - A reset mid-access abandons the beat; mem_req is low the next cycle. The memory must tolerate a dropped request.
- ls_src codes:
  - 000 word, 001 half signed, 101 half unsigned, 011 byte signed, 100 byte unsigned.
  - 010, 110 and 111 are illegal.
- Lane math (registered at accept): off = addr[1:0]; mask = 1 / 3 / F for byte / half / word.
  - be8 = mask << off (8 bits).
  - wd64 = zero-extended wdata << 8*off (64 bits).
  - split = |be8[7:4].
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - stall = req_valid.
  - If req_valid and ls_src is legal: latch the request and go to BEAT0.
  - If req_valid and ls_src is illegal: go to DONE with a fault and perform no bus access.
- BEAT0:
  - mem_req = 1, mem_addr = {addr[31:2], 2'b00}, mem_be = be8[3:0], mem_wdata = wd64[31:0], mem_we = data_write_en; stall = 1.
  - On mem_ready: capture mem_rdata into lo, then go to BEAT1 if split, else DONE.
- BEAT1:
  - mem_addr = word address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mem_be = be8[7:4], mem_wdata = wd64[63:32]; stall = 1.
  - On mem_ready: capture mem_rdata into hi, then go to DONE.
- Bus signals stay stable while mem_req is high and mem_ready is low. There is no timeout; the unit waits indefinitely.
- DONE:
  - resp_valid = 1, stall = 0, mem_req = 0; always returns to IDLE next cycle.
  - For loads: rdata = ls_extender({hi, lo} >> 8*off, ls_src). hi is 0 when there is no split.
  - For stores: rdata = 0.
  - ls_fault = 1 only when DONE was entered from an illegal code.
- Latency: aligned access with mem_ready high in BEAT0 takes 3 cycles from req_valid to resp_valid, with stall high for 2 of them. A split access adds one cycle per beat; each wait cycle adds one.
- req_valid is ignored outside IDLE. The core's retire edge is the end of the DONE cycle.

Decomposition:
- ls_pkg holds:
  - ls_src_t enum: LS_WORD = 3'b000, LS_HALF = 3'b001, LS_BYTE = 3'b011, LS_BYTEU = 3'b100, LS_HALFU = 3'b101.
  - lsu_state_t enum: IDLE, BEAT0, BEAT1, DONE.
  - Function ls_legal().
- One combinational sub-module, ls_extender (data_in[31:0], ls_src → data_out[31:0]), performs byte/half sign or zero extension. It is reused by any future load path.

Test Plan:
- Aligned LW, addr 0x100, mem_ready=1, mem_rdata=0xDEADBEEF → mem_be=F, mem_addr=0x100; resp_valid on the 3rd cycle with rdata=0xDEADBEEF; stall high 2 cycles.
- LB vs LBU at addr 0x203, mem_rdata=0x80000000 → mem_be=8; rdata=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH at addr 0x102, wdata=0x0000ABCD → single beat, mem_addr=0x100, mem_be=C, mem_wdata[31:16]=0xABCD, mem_we=1.
- Misaligned LW at addr 0x1FF, beat0 rdata=0x11223344, beat1 rdata=0x55667788 → beat0 addr 0x1FC be=8; beat1 addr 0x200 be=7; rdata=0x66778811. Also SW at 0xFFFFFFFE → beat1 mem_addr=0x00000000.
- mem_ready held low 4 cycles in BEAT0 → mem_req, mem_addr, mem_be and mem_wdata stable throughout; stall high; resp_valid only after ready.
- Illegal ls_src=3'b110 → no mem_req; DONE pulse with ls_fault=1. Separately, rst=0 during BEAT1 → next cycle IDLE, mem_req=0, stall=0, no resp_valid.
